// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: streams 16-bit limbs LS-first through one Sklansky adder.
// Optional feature macro: MPADD_ZERO_FLAG_EN adds out_zero (every result limb of the operation was zero).

module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    localparam int unsigned W      = 16;
    localparam int unsigned LEVELS = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W:0]   c;

    // Sklansky tree: at level k, bits with bit k set merge with the top bit of the lower half-block
    always_comb begin
        g = a & b;
        p = a ^ b;
        gn = g;
        pn = p;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            gn = g;
            pn = p;
            for (int unsigned i = 0; i < W; i++) begin
                if (((i >> k) & 1) == 1) begin
                    gn[i] = g[i] | (p[i] & g[((i >> k) << k) - 1]);
                    pn[i] = p[i] & p[((i >> k) << k) - 1];
                end
            end
            g = gn;
            p = pn;
        end
        c    = {g | (p & {W{cin}}), cin};
        sum  = a ^ b ^ c[W-1:0];
        cout = c[W];
    end
endmodule

module mpadd_seq #(
    parameter int unsigned MAX_LIMBS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_first,
    input  logic        in_last,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        out_ovf,
`ifdef MPADD_ZERO_FLAG_EN
    output logic        out_zero,
`endif
    output logic        out_err
);
    localparam int unsigned LIMB_W = 16;
    localparam int unsigned CNT_W  = $clog2(MAX_LIMBS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx;
    logic              carry_q;
    logic              sub_q;
    logic              accept;
    logic              first_eff;
    logic              sub_eff;
    logic              last_eff;
    logic              force_last;
    logic              proto_err;
    logic              cin;
    logic [LIMB_W-1:0] b_eff;
    logic [LIMB_W-1:0] sum;
    logic              cout;
    logic              ovf;

    assign in_ready = !out_valid || out_ready;

    // A limb arriving with no open operation always starts a fresh one
    always_comb begin
        state_d    = state_q;
        accept     = in_valid && in_ready;
        first_eff  = in_first || (state_q == IDLE);
        sub_eff    = first_eff ? in_sub : sub_q;
        cin        = first_eff ? in_sub : carry_q;
        b_eff      = in_b ^ {LIMB_W{sub_eff}};
        idx        = first_eff ? '0 : cnt_q;
        force_last = !in_last && (idx == CNT_W'(MAX_LIMBS - 1));
        last_eff   = in_last || force_last;
        proto_err  = (in_first ? (state_q == RUN) : (state_q == IDLE)) || force_last;
        if (accept) begin
            state_d = last_eff ? IDLE : RUN;
        end
    end

    adder u_adder (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // Carry into the MSB recovered from the sum bit, compared with the carry out
    assign ovf = in_a[LIMB_W-1] ^ b_eff[LIMB_W-1] ^ sum[LIMB_W-1] ^ cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            carry_q   <= cout;
            sub_q     <= sub_eff;
            cnt_q     <= idx + CNT_W'(1);
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= last_eff;
            out_cout  <= last_eff && cout;
            out_ovf   <= last_eff && ovf;
            out_err   <= out_err || proto_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MPADD_ZERO_FLAG_EN
    logic zacc_q;
    logic zero_all;

    assign zero_all = (first_eff || zacc_q) && (sum == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zacc_q   <= 1'b0;
            out_zero <= 1'b0;
        end else if (accept) begin
            zacc_q   <= zero_all;
            out_zero <= last_eff && zero_all;
        end
    end
`endif

endmodule

// File: tb/tb_mpadd_seq.sv
// Bench for mpadd_seq: fixed vectors, hand-written protocol corner cases, and random
// operations checked against a whole-operand arithmetic reference model.

module tb_mpadd_seq;
    localparam int MAX = 8;
    localparam int BW  = 16 * MAX + 1;
    localparam int NV  = 9;
`ifdef MPADD_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        last;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          n;
        logic        sub;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_first;
    logic        in_last;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        out_ovf;
    logic        out_err;
    logic        out_zero_w;

    mpadd_seq #(.MAX_LIMBS(MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
`ifdef MPADD_ZERO_FLAG_EN
        .out_zero  (out_zero_w),
`endif
        .out_err   (out_err)
    );

`ifndef MPADD_ZERO_FLAG_EN
    assign out_zero_w = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // reference model state: limbs of the open operation, kept as whole numbers
    logic [15:0] op_a [MAX];
    logic [15:0] op_b [MAX];
    int          m_cnt;
    bit          m_open;
    bit          m_sub;
    bit          m_err;
    res_t        exp_q [$];
    int          n_pass;
    int          n_total;
    int          n_limbs;
    bit          rnd_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic res_t model_step(input logic [15:0] a, input logic [15:0] b,
                                        input logic first, input logic last, input logic sub);
        logic [BW-1:0] av, bv, mask, full, res;
        bit            lastf;
        res_t          r;
        if (first || !m_open) begin
            if (first == m_open) m_err = 1'b1;
            m_cnt = 0;
            m_sub = sub;
        end
        op_a[m_cnt] = a;
        op_b[m_cnt] = b;
        m_cnt++;
        lastf = last || (m_cnt == MAX);
        if (!last && m_cnt == MAX) m_err = 1'b1;
        av = '0;
        bv = '0;
        for (int i = 0; i < m_cnt; i++) begin
            av[16*i +: 16] = op_a[i];
            bv[16*i +: 16] = op_b[i];
        end
        mask = (BW'(1) << (16 * m_cnt)) - BW'(1);
        if (m_sub) bv = ~bv & mask;
        full   = av + bv + BW'(m_sub);
        res    = full & mask;
        r.sum  = res[16*(m_cnt-1) +: 16];
        r.last = lastf;
        r.cout = lastf && full[16*m_cnt];
        r.ovf  = lastf && (av[16*m_cnt-1] == bv[16*m_cnt-1]) && (res[16*m_cnt-1] != av[16*m_cnt-1]);
        r.zero = ZEN && lastf && (res == '0);
        r.err  = m_err;
        m_open = !lastf;
        return r;
    endfunction

    function automatic logic [15:0] rand_limb();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    // called at a falling edge: a transfer happens at the next rising edge
    task automatic sample();
        res_t o, e;
        if (!rst && out_valid && out_ready) begin
            o.sum  = out_sum;
            o.last = out_last;
            o.cout = out_cout;
            o.ovf  = out_ovf;
            o.zero = out_zero_w;
            o.err  = out_err;
            n_limbs++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_limb%0d: got {sum,last,cout,ovf,zero,err}=0x%0h, expected no output", n_limbs, o);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("limb%0d{sum,last,cout,ovf,zero,err}", n_limbs), 32'(o), 32'(e));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic first,
                         input logic last, input logic sub, output bit acc);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        in_sub   = sub;
        acc      = 1'b0;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clk);
            sample();
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_total++;
            $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] b, input logic first,
                       input logic last, input logic sub);
        bit acc;
        drive(a, b, first, last, sub, acc);
        if (acc) exp_q.push_back(model_step(a, b, first, last, sub));
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) cycle();
        chk("pending_limbs", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t tv [NV];
    res_t held;

    initial begin
        n_pass = 0; n_total = 0; n_limbs = 0; rnd_rdy = 1'b0;
        m_cnt = 0; m_open = 1'b0; m_sub = 1'b0; m_err = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

        tv[0] = '{a:64'h0001_FFFF, b:64'h0000_0001, r:64'h0002_0000, n:2, sub:1'b0, cout:1'b0, ovf:1'b0, zero:1'b0};
        tv[1] = '{a:64'h0000_0000, b:64'h0000_0001, r:64'hFFFF_FFFF, n:2, sub:1'b1, cout:1'b0, ovf:1'b0, zero:1'b0};
        tv[2] = '{a:64'h7FFF, b:64'h0001, r:64'h8000, n:1, sub:1'b0, cout:1'b0, ovf:1'b1, zero:1'b0};
        tv[3] = '{a:64'h1234, b:64'h1234, r:64'h0000, n:1, sub:1'b1, cout:1'b1, ovf:1'b0, zero:1'b1};
        tv[4] = '{a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h1, r:64'h0, n:4, sub:1'b0, cout:1'b1, ovf:1'b0, zero:1'b1};
        tv[5] = '{a:64'h8000_0000_0000, b:64'h1, r:64'h7FFF_FFFF_FFFF, n:3, sub:1'b1, cout:1'b1, ovf:1'b1, zero:1'b0};
        tv[6] = '{a:64'h1234_5678, b:64'h1111_9999, r:64'h2345_F011, n:2, sub:1'b0, cout:1'b0, ovf:1'b0, zero:1'b0};
        tv[7] = '{a:64'h0001_0000, b:64'h0000_0001, r:64'h0000_FFFF, n:2, sub:1'b1, cout:1'b1, ovf:1'b0, zero:1'b0};
        tv[8] = '{a:64'h8000_0000_0000, b:64'h8000_0000_0000, r:64'h0, n:3, sub:1'b0, cout:1'b1, ovf:1'b1, zero:1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MPADD_ZERO_FLAG_EN
        chk("rst_out_zero", 32'(out_zero_w), 32'd0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // fixed vectors, back to back
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < tv[v].n; i++) begin
                bit   acc;
                bit   lst;
                res_t e;
                lst = (i == tv[v].n - 1);
                drive(tv[v].a[16*i +: 16], tv[v].b[16*i +: 16], i == 0, lst, tv[v].sub, acc);
                if (acc) begin
                    void'(model_step(tv[v].a[16*i +: 16], tv[v].b[16*i +: 16], i == 0, lst, tv[v].sub));
                    e.sum  = tv[v].r[16*i +: 16];
                    e.last = lst;
                    e.cout = lst && tv[v].cout;
                    e.ovf  = lst && tv[v].ovf;
                    e.zero = ZEN && lst && tv[v].zero;
                    e.err  = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
        drain();

        // backpressure: 3 stalled cycles in the middle of a 4-limb add
        put(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        put(16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0);
        held = (exp_q.size() != 0) ? exp_q[$] : '0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h8000; in_b = 16'h8000;
        in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sample();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_sum", 32'(out_sum), 32'(held.sum));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        put(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        put(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
        drain();

        // new operation started while one is open: stale carry must not leak
        put(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        put(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        put(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
        drain();
        chk("err_sticky", 32'(out_err), 32'(m_err));

        // nine limbs without in_last: eighth is forced last, ninth starts afresh
        for (int i = 0; i < 9; i++) put(16'hFFFF, 16'h0001, i == 0, 1'b0, 1'b0);
        put(16'h0002, 16'h0003, 1'b1, 1'b1, 1'b1);
        drain();

        // reset while a limb is held and a subtract is open
        out_ready = 1'b0;
        put(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_err", 32'(out_err), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_open = 1'b0; m_err = 1'b0; m_cnt = 0; m_sub = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        put(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        drain();

        // random well-formed operations with random gaps and backpressure
        rnd_rdy = 1'b1;
        for (int op = 0; op < 60; op++) begin
            int n;
            bit s;
            n = int'($urandom_range(1, MAX));
            s = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) cycle();
                put(rand_limb(), rand_limb(), i == 0, i == n - 1,
                    (i == 0) ? s : 1'($urandom_range(0, 1)));
            end
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mpadd_seq.md
# mpadd_seq

Multi-precision add/subtract sequencer wrapped around the team's 16-bit Sklansky prefix adder (`adder`). It accepts operands as a stream of 16-bit limbs, least-significant limb first. It drives one combinational `adder` instance per cycle, holds the inter-limb carry in a register, and returns result limbs through a registered valid/ready output stage. It serves as the shared wide-integer arithmetic engine for datapaths that need 32- to 256-bit add/sub without a wider carry tree.

## Interface
- `MAX_LIMBS`, default 8: maximum limbs per operation (2..16); the counter is `$clog2(MAX_LIMBS)` bits wide.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  limb offered.
- `in_ready`  out  1  limb accepted when `in_valid && in_ready`.
- `in_a`, `in_b`  in  16 each  operand limbs.
- `in_first`  in  1  limb is the least-significant limb of a new operation.
- `in_last`  in  1  limb is the most-significant limb.
- `in_sub`  in  1  subtract (A−B); sampled on the first limb only, ignored on later limbs.
- `out_valid`  out  1  result limb held.
- `out_ready`  in  1  downstream accepts.
- `out_sum`  out  16  result limb.
- `out_last`  out  1  final limb of the operation.
- `out_cout`  out  1  carry out of the MSB limb (for subtract, 1 = no borrow); valid with `out_last`, 0 otherwise.
- `out_ovf`  out  1  two's-complement overflow; valid with `out_last`, 0 otherwise.
- `out_err`  out  1  sticky protocol error; cleared only by `rst`.

## Operation
- Reset is synchronous and active-high.
- FSM states:
  - IDLE: no operation open.
  - RUN: operation open, carry register live.
- Adder inputs per accepted limb:
  - a = `in_a`.
  - b = `in_b` ^ {16{sub_q}}.
  - cin = `in_first` ? `in_sub` : carry_q.
  - sub_q is latched from `in_sub` on the first limb; the first limb uses `in_sub` directly.
- On acceptance:
  - carry_q ← adder cout.
  - The output register loads the sum, `out_last` = `in_last` (or forced), and flags.
  - The limb counter increments; it resets to 0 on the first limb.
- Transitions:
  - IDLE + accepted `in_first` → RUN, or stays IDLE if `in_last` is also set (single-limb op).
  - RUN + accepted `in_last` → IDLE.
- Boundary conditions:
  - IDLE + accepted limb without `in_first`: treated as first (cin = `in_sub`, sub latched); `out_err` set.
  - RUN + accepted `in_first`: the open operation is abandoned (no `out_last` emitted for it); the new operation starts; `out_err` set.
  - Limb count reaches `MAX_LIMBS` without `in_last`: that limb is emitted with `out_last`=1; FSM → IDLE; `out_err` set.
- Flags on the last limb:
  - `out_ovf` = carry into bit 15 XOR cout, where carry into bit 15 = a[15]^b'[15]^sum[15].
  - `out_cout` = cout.
- Width rule: result is modulo 2^(16·n); no limb is ever widened.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`.
- Throughput: 1 limb per cycle while `out_ready`=1.
- `in_ready` = !`out_valid` || `out_ready` (combinational; one-deep output register, no skid buffer).
- Output held stable while `out_valid` && !`out_ready`.
- `out_valid` falls the cycle after acceptance unless a new limb is loaded in the same cycle.
- `in_ready` never depends on `in_valid`.
- Reset values: `out_valid`=0, `out_sum`=0, `out_last`=0, `out_cout`=0, `out_ovf`=0, `out_err`=0, `out_zero`=0; state IDLE, carry_q=0, counter=0.
- `rst` mid-operation discards the open operation and any held output limb; no partial `out_last` is produced.

## Configuration
- `MPADD_ZERO_FLAG_EN` defined:
  - Adds output port `out_zero` (1 bit).
  - A zero-accumulator ANDs (sum == 0) across all limbs of the operation.
  - `out_zero` = 1 on the `out_last` limb iff every result limb was zero; 0 on all other limbs.
- `MPADD_ZERO_FLAG_EN` undefined:
  - Port `out_zero` and the accumulator are absent.
  - All other behaviour is identical.

## Test plan
- Single 2-limb add, A=0x0001_FFFF, B=0x0000_0001, `out_ready`=1 → limbs 0x0000 then 0x0002; `out_cout`=0, `out_ovf`=0; `out_last` on limb 2.
- Subtract, 2 limbs, A=0x0000_0000, B=0x0000_0001 → 0xFFFF, 0xFFFF; `out_cout`=0 (borrow); `out_ovf`=0; `out_zero`=0 if enabled.
- Signed overflow, 1 limb, first+last, 0x7FFF+0x0001 → 0x8000, `out_ovf`=1, `out_cout`=0. Then A−A with A=0x1234 → 0x0000, `out_cout`=1, `out_zero`=1 if enabled.
- Backpressure: hold `out_ready`=0 for 3 cycles mid 4-limb op → `in_ready`=0, `out_sum` stable, carry unchanged; after release, results match the unstalled run.
- Protocol errors, in sequence:
  - `in_first` during RUN → new op result correct, `out_err`=1.
  - With `MAX_LIMBS`=8, 9 limbs without `in_last` → limb 8 carries `out_last`=1, FSM back in IDLE.
- `rst` asserted while a limb is held and the FSM is in RUN → next cycle `out_valid`=0, `out_err`=0. Following op 0xFFFF+0x0001 (1 limb) yields 0x0000 with `out_cout`=1 (no stale carry or sub).
